// File: rtl/mont_job_scheduler.sv
// Two-requester job scheduler for a shared protected Montgomery multiplier core.
// Define MONT_SCHED_RETRY_EN to compile in re-execution after a core timeout.
module mont_job_scheduler #(
   parameter int WORD_SIZE = 64,
   parameter int NUM_WORDS = 64,
   parameter int TIMEOUT   = 20000,
   parameter int MAX_RETRY = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [1:0]           req,
   output logic [1:0]           gnt,
   input  logic                 wr_valid,
   input  logic [WORD_SIZE-1:0] wr_data,
   output logic                 wr_ready,
   output logic                 core_reset,
   output logic [WORD_SIZE-1:0] core_bus,
   input  logic                 core_flag,
   output logic                 done,
   output logic                 fail,
   output logic [1:0]           retries
);

   localparam int WCNT_W = $clog2(NUM_WORDS + 1);
   localparam int IDX_W  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   localparam int TCNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      CRST   = 3'd2,
      STREAM = 3'd3,
      WAIT   = 3'd4,
      DONE   = 3'd5,
      FAIL   = 3'd6
   } state_t;

   state_t               state_r;
   logic [1:0]           gnt_r;
   logic                 last_r;
   logic                 wr_ready_r;
   logic                 core_reset_r;
   logic [WORD_SIZE-1:0] core_bus_r;
   logic                 done_r;
   logic                 fail_r;
   logic [WCNT_W-1:0]    wcnt_r;
   logic [WCNT_W-1:0]    rd_r;
   logic [TCNT_W-1:0]    tcnt_r;
   logic [WORD_SIZE-1:0] buffer_r [NUM_WORDS];

   logic wr_fire_s;
   logic last_word_s;
   logic timeout_s;
   logic pick_s;
   logic retry_ok_s;

   assign wr_fire_s   = (state_r == LOAD) && wr_valid && wr_ready_r;
   assign last_word_s = (wcnt_r == WCNT_W'(NUM_WORDS - 1));
   assign timeout_s   = (tcnt_r == TCNT_W'(TIMEOUT - 1));
   // With both requesting, the one not granted last wins; otherwise the lone requester.
   assign pick_s      = (req == 2'b11) ? ~last_r : req[1];

`ifdef MONT_SCHED_RETRY_EN
   logic [1:0] retries_r;

   assign retry_ok_s = (retries_r < 2'(MAX_RETRY));

   // Retry count: cleared on a new grant, bumped on every re-execution.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         retries_r <= 2'd0;
      end else if (state_r == IDLE && req != 2'b00) begin
         retries_r <= 2'd0;
      end else if (state_r == WAIT && !core_flag && timeout_s && retry_ok_s) begin
         retries_r <= retries_r + 2'd1;
      end
   end

   assign retries = retries_r;
`else
   assign retry_ok_s = 1'b0;
   assign retries    = 2'd0;
`endif

   // Operand buffer; unreset, only read after a complete load.
   always_ff @(posedge clk) begin
      if (wr_fire_s) begin
         buffer_r[wcnt_r[IDX_W-1:0]] <= wr_data;
      end
   end

   // Job sequencer with registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r      <= IDLE;
         gnt_r        <= 2'b00;
         last_r       <= 1'b1;
         wr_ready_r   <= 1'b0;
         core_reset_r <= 1'b1;
         core_bus_r   <= '0;
         done_r       <= 1'b0;
         fail_r       <= 1'b0;
         wcnt_r       <= '0;
         rd_r         <= '0;
         tcnt_r       <= '0;
      end else begin
         case (state_r)
            IDLE: begin
               core_reset_r <= 1'b1;
               core_bus_r   <= '0;
               if (req != 2'b00) begin
                  gnt_r      <= pick_s ? 2'b10 : 2'b01;
                  last_r     <= pick_s;
                  wcnt_r     <= '0;
                  wr_ready_r <= 1'b1;
                  state_r    <= LOAD;
               end
            end
            LOAD: begin
               if (wr_fire_s) begin
                  wcnt_r <= wcnt_r + WCNT_W'(1);
                  if (last_word_s) begin
                     wr_ready_r <= 1'b0;
                     rd_r       <= '0;
                     state_r    <= CRST;
                  end
               end
            end
            CRST: begin
               core_reset_r <= 1'b0;
               core_bus_r   <= buffer_r[rd_r[IDX_W-1:0]];
               rd_r         <= rd_r + WCNT_W'(1);
               state_r      <= STREAM;
            end
            STREAM: begin
               if (rd_r == WCNT_W'(NUM_WORDS)) begin
                  core_bus_r <= '0;
                  tcnt_r     <= '0;
                  state_r    <= WAIT;
               end else begin
                  core_bus_r <= buffer_r[rd_r[IDX_W-1:0]];
                  rd_r       <= rd_r + WCNT_W'(1);
               end
            end
            WAIT: begin
               // A flag arriving in the timeout cycle still counts as success.
               if (core_flag) begin
                  done_r       <= 1'b1;
                  core_reset_r <= 1'b1;
                  state_r      <= DONE;
               end else if (timeout_s) begin
                  core_reset_r <= 1'b1;
                  if (retry_ok_s) begin
                     rd_r    <= '0;
                     state_r <= CRST;
                  end else begin
                     fail_r  <= 1'b1;
                     state_r <= FAIL;
                  end
               end else begin
                  tcnt_r <= tcnt_r + TCNT_W'(1);
               end
            end
            DONE, FAIL: begin
               done_r  <= 1'b0;
               fail_r  <= 1'b0;
               gnt_r   <= 2'b00;
               state_r <= IDLE;
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign gnt        = gnt_r;
   assign wr_ready   = wr_ready_r;
   assign core_reset = core_reset_r;
   assign core_bus   = core_bus_r;
   assign done       = done_r;
   assign fail       = fail_r;

endmodule
